// File: rtl/mixer_pkg.sv
// Shared definitions for the multi-channel mixer: pan codes, sequencer
// states, reset configuration values and a constant clog2 helper.
package mixer_pkg;

    typedef enum logic [1:0] {
        PAN_OFF   = 2'b00,
        PAN_LEFT  = 2'b01,
        PAN_RIGHT = 2'b10,
        PAN_BOTH  = 2'b11
    } pan_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_LATCH = 1'b1
    } seq_state_t;

    localparam logic [3:0] VOL_RESET = 4'd15;
    localparam pan_t       PAN_RESET = PAN_BOTH;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sd_dac_channel.sv
// First-order sigma-delta modulator: the carry out of a DW-bit phase
// accumulator forms the PDM bitstream, so ones density tracks the word.
module sd_dac_channel
    import mixer_pkg::*;
#(
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] word,
    output logic          pdm
);

    logic [DW:0] acc;

    // Accumulate the word onto the residue, dropping the previous carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[DW-1:0]} + {1'b0, word};
        end
    end

    assign pdm = acc[DW];

endmodule

// File: rtl/multi_channel_mixer.sv
// Time-multiplexed stereo mixer: one channel is scaled, panned and summed
// per clock, the sums are saturated into DAC words once per frame and each
// side drives a sigma-delta modulator.
module multi_channel_mixer
    import mixer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 12,
    parameter int DW  = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*IW-1:0] ch_in,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [5:0]       wr_data,
    output logic             audio_out_left,
    output logic             audio_out_right,
    output logic             sample_stb
);

    localparam int AW = IW + clog2(NCH) + 1;
    localparam int PW = IW + 4;
    localparam int CW = (AW > DW) ? AW : DW;
    localparam logic [CW-1:0] SAT_MAX = CW'({DW{1'b1}});

    seq_state_t    state, state_next;
    logic [3:0]    idx, idx_next;

    logic [3:0]    act_vol [NCH];
    pan_t          act_pan [NCH];
    logic [3:0]    shd_vol [NCH];
    pan_t          shd_pan [NCH];

    logic [IW-1:0] cur_sample;
    logic [3:0]    cur_vol;
    pan_t          cur_pan;
    logic [PW-1:0] product;
    logic [IW-1:0] scaled;
    logic [AW-1:0] add_left, add_right;
    logic [AW-1:0] acc_left, acc_right;
    logic [DW-1:0] sat_left, sat_right;
    logic [DW-1:0] dac_word_left, dac_word_right;
    logic          stb;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Sequencer next state: NCH accumulate steps followed by one latch step.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_ACCUM: begin
                if (idx == 4'(NCH - 1)) begin
                    state_next = ST_LATCH;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 4'd1;
                end
            end
            ST_LATCH: begin
                state_next = ST_ACCUM;
                idx_next   = '0;
            end
            default: begin
                state_next = ST_ACCUM;
                idx_next   = '0;
            end
        endcase
    end

    // Select the live sample and active config of the channel being summed.
    always_comb begin
        cur_sample = '0;
        cur_vol    = '0;
        cur_pan    = PAN_OFF;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (idx == k[3:0]) begin
                cur_sample = ch_in[k*IW +: IW];
                cur_vol    = act_vol[k];
                cur_pan    = act_pan[k];
            end
        end
    end

    // Volume scaling by (vol+1)/16 and routing to the selected sides.
    always_comb begin
        product   = PW'(cur_sample) * PW'({1'b0, cur_vol} + 5'd1);
        scaled    = product[PW-1:4];
        add_left  = '0;
        add_right = '0;
        if (cur_pan == PAN_LEFT || cur_pan == PAN_BOTH) begin
            add_left = AW'(scaled);
        end
        if (cur_pan == PAN_RIGHT || cur_pan == PAN_BOTH) begin
            add_right = AW'(scaled);
        end
    end

    // Frame accumulators; index 0 restarts the sum instead of adding to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_left  <= '0;
            acc_right <= '0;
        end else if (state == ST_ACCUM) begin
            acc_left  <= (idx == '0 ? '0 : acc_left) + add_left;
            acc_right <= (idx == '0 ? '0 : acc_right) + add_right;
        end
    end

    // Clamp the frame sums to the DAC range.
    always_comb begin
        sat_left  = (CW'(acc_left) > SAT_MAX) ? '1 : DW'(acc_left);
        sat_right = (CW'(acc_right) > SAT_MAX) ? '1 : DW'(acc_right);
    end

    // DAC words and the strobe that marks their first valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_word_left  <= '0;
            dac_word_right <= '0;
            stb            <= 1'b0;
        end else begin
            stb <= (state == ST_LATCH);
            if (state == ST_LATCH) begin
                dac_word_left  <= sat_left;
                dac_word_right <= sat_right;
            end
        end
    end

    // Shadow config takes writes; active config reloads from shadow at latch.
    // Non-blocking update means a write in the latch cycle misses this reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                act_vol[k] <= VOL_RESET;
                act_pan[k] <= PAN_RESET;
                shd_vol[k] <= VOL_RESET;
                shd_pan[k] <= PAN_RESET;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (state == ST_LATCH) begin
                    act_vol[k] <= shd_vol[k];
                    act_pan[k] <= shd_pan[k];
                end
                if (wr_en && wr_addr == k[3:0]) begin
                    shd_vol[k] <= wr_data[3:0];
                    shd_pan[k] <= pan_t'(wr_data[5:4]);
                end
            end
        end
    end

    assign sample_stb = stb;

    sd_dac_channel #(.DW(DW)) u_dac_left (
        .clk   (clk),
        .rst_n (rst_n),
        .word  (dac_word_left),
        .pdm   (audio_out_left)
    );

    sd_dac_channel #(.DW(DW)) u_dac_right (
        .clk   (clk),
        .rst_n (rst_n),
        .word  (dac_word_right),
        .pdm   (audio_out_right)
    );

endmodule

// File: tb/tb_multi_channel_mixer.sv
// Self-checking bench for multi_channel_mixer: a frame-level reference
// model tracks the expected DAC words and strobe every clock.
module tb_multi_channel_mixer;

    localparam int NCH  = 4;
    localparam int IW   = 12;
    localparam int DW   = 13;
    localparam int FMAX = (1 << DW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*IW-1:0] ch_in;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [5:0]        wr_data;
    logic              audio_out_left;
    logic              audio_out_right;
    logic              sample_stb;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int phase;
    int frame_s [NCH];
    int act_v [NCH];
    int act_p [NCH];
    int sh_v [NCH];
    int sh_p [NCH];
    int exp_l, exp_r;
    bit exp_stb;
    int ones_l, ones_r;

    multi_channel_mixer #(.NCH(NCH), .IW(IW), .DW(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ch_in           (ch_in),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .audio_out_left  (audio_out_left),
        .audio_out_right (audio_out_right),
        .sample_stb      (sample_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv, input int tol = 0);
        int d;
        n_tests++;
        d = obs - expv;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, expv, tol, $time);
        end
    endtask

    task automatic model_reset();
        phase   = 0;
        exp_l   = 0;
        exp_r   = 0;
        exp_stb = 0;
        for (int k = 0; k < NCH; k++) begin
            act_v[k] = 15; act_p[k] = 3;
            sh_v[k]  = 15; sh_p[k]  = 3;
            frame_s[k] = 0;
        end
    endtask

    // Mix one frame from the captured samples and the active config.
    task automatic model_mix();
        int sl, sr, s;
        sl = 0; sr = 0;
        for (int k = 0; k < NCH; k++) begin
            s = (frame_s[k] * (act_v[k] + 1)) / 16;
            if (act_p[k] == 1 || act_p[k] == 3) sl += s;
            if (act_p[k] == 2 || act_p[k] == 3) sr += s;
        end
        exp_l = (sl > FMAX) ? FMAX : sl;
        exp_r = (sr > FMAX) ? FMAX : sr;
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (phase < NCH) begin
                frame_s[phase] = int'(ch_in[phase*IW +: IW]);
                phase++;
                exp_stb = 0;
            end else begin
                model_mix();
                for (int k = 0; k < NCH; k++) begin
                    act_v[k] = sh_v[k];
                    act_p[k] = sh_p[k];
                end
                exp_stb = 1;
                phase   = 0;
            end
            if (wr_en && int'(wr_addr) < NCH) begin
                sh_v[wr_addr] = int'(wr_data[3:0]);
                sh_p[wr_addr] = int'(wr_data[5:4]);
            end
        end
        #1;
        ones_l += int'(audio_out_left);
        ones_r += int'(audio_out_right);
        check("stb", int'(sample_stb), int'(exp_stb));
        check("word_l", int'(dut.dac_word_left), exp_l);
        check("word_r", int'(dut.dac_word_right), exp_r);
        if (!rst_n) begin
            check("rst_out_l", int'(audio_out_left), 0);
            check("rst_out_r", int'(audio_out_right), 0);
        end
    endtask

    task automatic set_ch(input int k, input int v);
        ch_in[k*IW +: IW] = IW'(v);
    endtask

    task automatic write_cfg(input int addr, input int pan, input int vol);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = {2'(pan), 4'(vol)};
        tick();
        wr_en   = 1'b0;
    endtask

    // Advance to the cycle right after the next latch edge.
    task automatic wait_latch();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!exp_stb && n < 2 * (NCH + 1));
        if (!exp_stb) check("latch_timeout", 0, 1);
    endtask

    task automatic settle();
        repeat (3) wait_latch();
    endtask

    // Advance until the next edge will process sequencer position p.
    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (phase != p && n < 2 * (NCH + 1)) begin
            tick();
            n++;
        end
        if (phase != p) check("phase_timeout", phase, p);
    endtask

    task automatic measure(input int n);
        ones_l = 0;
        ones_r = 0;
        repeat (n) tick();
    endtask

    initial begin
        int cnt;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        ch_in   = '0;
        ones_l  = 0;
        ones_r  = 0;
        model_reset();

        // Reset held 10 clocks with changing inputs
        repeat (10) begin
            for (int k = 0; k < NCH; k++) set_ch(k, $urandom_range(0, 4095));
            tick();
        end
        rst_n = 1'b1;
        cnt = 0;
        while (!sample_stb && cnt < 4 * (NCH + 2)) begin
            tick();
            cnt++;
        end
        // clock periods counted including the one in which rst_n rises
        check("rst_first_stb", cnt + 1, NCH + 2);

        // Pan left only
        for (int k = 0; k < NCH; k++) set_ch(k, $urandom_range(0, 4095));
        set_ch(0, 2048);
        write_cfg(0, 1, 15);
        for (int k = 1; k < NCH; k++) write_cfg(k, 0, 15);
        settle();
        check("panl_word_l", int'(dut.dac_word_left), 2048);
        check("panl_word_r", int'(dut.dac_word_right), 0);
        measure(1 << DW);
        check("panl_ones_l", ones_l, 2048, 1);
        check("panl_ones_r", ones_r, 0);

        // Saturation with all channels full scale on both sides
        for (int k = 0; k < NCH; k++) begin
            set_ch(k, 4095);
            write_cfg(k, 3, 15);
        end
        settle();
        check("sat_word_l", int'(dut.dac_word_left), 8191);
        check("sat_word_r", int'(dut.dac_word_right), 8191);
        measure(1 << DW);
        check("sat_ones_l", ones_l, 8191, 1);
        check("sat_ones_r", ones_r, 8191, 1);

        // Volume scaling on a right-only channel
        for (int k = 0; k < NCH; k++) write_cfg(k, 0, 15);
        set_ch(1, 1000);
        write_cfg(1, 2, 7);
        settle();
        check("vol_word_r", int'(dut.dac_word_right), 500);
        check("vol_word_l", int'(dut.dac_word_left), 0);

        // Write during accumulate index 2 applies from the next frame
        write_cfg(1, 0, 15);
        set_ch(0, 2048);
        write_cfg(0, 1, 15);
        settle();
        wait_phase(2);
        write_cfg(0, 1, 0);
        wait_latch();
        check("wacc_cur", int'(dut.dac_word_left), 2048);
        wait_latch();
        check("wacc_next", int'(dut.dac_word_left), 128);

        // Write in the latch cycle applies one frame later
        write_cfg(0, 1, 15);
        settle();
        wait_phase(NCH);
        write_cfg(0, 1, 0);
        check("wlat_f0", int'(dut.dac_word_left), 2048);
        wait_latch();
        check("wlat_f1", int'(dut.dac_word_left), 2048);
        wait_latch();
        check("wlat_f2", int'(dut.dac_word_left), 128);

        // Mid-frame reset at accumulate index 1
        wait_latch();
        wait_phase(1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst_out_l", int'(audio_out_left), 0);
        check("mrst_out_r", int'(audio_out_right), 0);
        check("mrst_stb", int'(sample_stb), 0);
        check("mrst_word_l", int'(dut.dac_word_left), 0);
        check("mrst_word_r", int'(dut.dac_word_right), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        write_cfg(5, 0, 0);
        for (int k = 0; k < NCH; k++) set_ch(k, 400);
        settle();
        check("mrst_cfg_l", int'(dut.dac_word_left), 1600);
        check("mrst_cfg_r", int'(dut.dac_word_right), 1600);

        // Randomised inputs and config writes, including out-of-range addresses
        repeat (600) begin
            for (int k = 0; k < NCH; k++) set_ch(k, $urandom_range(0, 4095));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 6'($urandom_range(0, 63));
            tick();
        end
        wr_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multi_channel_mixer.md
MULTI_CHANNEL_MIXER -- requirements
Module: multi_channel_mixer

Interface
REQ-001 Parameter NCH, default 4, number of mono input channels (2..16).
REQ-002 Parameter IW, default 12, width of each unsigned channel sample.
REQ-003 Parameter DW, default 13, width of the unsigned DAC input words and sigma-delta modulators.
REQ-004 Port clk  input  1  single system clock, all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port ch_in  input  NCH*IW  packed unsigned samples, channel k at bits [k*IW +: IW].
REQ-007 Port wr_en  input  1  one-cycle config write strobe.
REQ-008 Port wr_addr  input  4  target channel index.
REQ-009 Port wr_data  input  6  {pan[1:0], vol[3:0]}.
REQ-010 Port audio_out_left  output  1  left PDM bitstream.
REQ-011 Port audio_out_right  output  1  right PDM bitstream.
REQ-012 Port sample_stb  output  1  one-cycle pulse when new DAC words load.

Function
REQ-013 Sequencer SHALL run continuously with states ACCUM (index 0..NCH-1, one channel per clock) then LATCH (one clock); frame = NCH+1 clocks.
REQ-014 In ACCUM index k, channel k SHALL be sampled directly from ch_in (no frame snapshot).
REQ-015 Scaled sample SHALL be (sample * (vol+1)) >> 4, IW bits; vol=15 is unity and vol=0 is 1/16.
REQ-016 Pan encoding SHALL be 00 off, 01 left, 10 right, 11 both; scaled sample is added to each selected accumulator.
REQ-017 Accumulators SHALL be IW+clog2(NCH)+1 bits wide, cleared at the start of each frame, with no overflow inside the frame.
REQ-018 At LATCH, each accumulator SHALL be saturated to DW bits (values above 2^DW-1 clamp to 2^DW-1) and registered as the DAC word.
REQ-019 sample_stb SHALL pulse high in the clock after LATCH, coinciding with the first cycle the new DAC words are valid.
REQ-020 Config writes SHALL go to per-channel shadow registers; wr_addr >= NCH SHALL be ignored.
REQ-021 Active config SHALL be copied from the shadow registers at LATCH, so a write during ACCUM takes effect in the next frame.
REQ-022 A write in the LATCH cycle SHALL reach the shadow registers only; the active copy takes the pre-write value, so the write applies one frame later.
REQ-023 Each output SHALL come from a first-order sigma-delta modulator: DW+1-bit accumulator acc <= acc[DW-1:0] + word; output = acc[DW], registered.
REQ-024 Ones density of each output over 2^DW clocks SHALL equal the DAC word ±1.

Reset
REQ-025 While rst_n is low: audio_out_left, audio_out_right and sample_stb SHALL be 0; DAC words and modulator accumulators 0; sequencer at ACCUM index 0; all active and shadow config vol=15, pan=11.
REQ-026 Reset asserted mid-frame SHALL abandon the partial frame; after release the first sample_stb occurs NCH+2 clocks later.

Structure
REQ-027 Shared package mixer_pkg SHALL hold the pan encodings, sequencer state enum, reset vol/pan constants and a clog2 function.
REQ-028 The modulator SHALL be sub-module sd_dac_channel (parameter DW), instantiated once per side.

Verification
REQ-029 Reset: hold rst_n low 10 clocks with random ch_in -> both outputs and sample_stb 0 throughout; first sample_stb NCH+2 clocks after release.
REQ-030 Pan left: ch0=2048, pan=01, vol=15; others pan=00 -> left word 2048, right word 0; left ones count over 8192 clocks = 2048±1; right all zero.
REQ-031 Saturation: all four channels 4095, vol=15, pan=11 -> sum 16380 clamps to 8191 on both words.
REQ-032 Volume: ch1=1000, vol=7, pan=10 -> right word 500, left word 0.
REQ-033 Write timing: write ch0 vol=0 at ACCUM index 2 with ch0=2048 -> current frame word 2048, next frame 128; same write in the LATCH cycle -> 2048 for two frames, then 128.
REQ-034 Mid-frame reset: assert rst_n at ACCUM index 1 -> outputs 0 immediately and config restored to vol=15, pan=11; a write to wr_addr=5 when NCH=4 changes nothing.
